// File: rtl/reservation_station_pkg.sv
// Shared widths, tag constants and entry state encoding for the reservation station.
`default_nettype none

package reservation_station_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 4;
  localparam logic [TAG_W-1:0] NO_TAG = 4'd0;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_WAITING   = 2'd1,
    ST_READY     = 2'd2,
    ST_EXECUTING = 2'd3
  } entry_state_t;
endpackage

`default_nettype wire

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an operation and its operands until
// both are valid, then tracks it through execution until its tag is broadcast.
`default_nettype none

module rs_entry
  import reservation_station_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  my_tag,
  input  logic              alloc,
  input  logic              dispatch,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_en,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  cdb_label,
  output entry_state_t      state,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  entry_state_t      state_nx;
  logic [OP_W-1:0]   op_nx;
  logic [DATA_W-1:0] vj_nx, vk_nx;
  logic [TAG_W-1:0]  qj, qk, qj_nx, qk_nx;
  logic              hit_j, hit_k;

  assign hit_j = cdb_en && (qj != NO_TAG) && (qj == cdb_label);
  assign hit_k = cdb_en && (qk != NO_TAG) && (qk == cdb_label);

  always_comb begin
    state_nx = state;
    op_nx    = op;
    vj_nx    = vj;
    vk_nx    = vk;
    qj_nx    = qj;
    qk_nx    = qk;
    case (state)
      ST_FREE: begin
        if (alloc) begin
          op_nx    = issue_op;
          vj_nx    = issue_vj;
          vk_nx    = issue_vk;
          qj_nx    = issue_qj;
          qk_nx    = issue_qk;
          state_nx = (issue_qj == NO_TAG && issue_qk == NO_TAG) ? ST_READY : ST_WAITING;
        end
      end
      ST_WAITING: begin
        if (hit_j) begin
          vj_nx = cdb_data;
          qj_nx = NO_TAG;
        end
        if (hit_k) begin
          vk_nx = cdb_data;
          qk_nx = NO_TAG;
        end
        if (qj_nx == NO_TAG && qk_nx == NO_TAG) state_nx = ST_READY;
      end
      ST_READY: begin
        if (dispatch) state_nx = ST_EXECUTING;
      end
      ST_EXECUTING: begin
        // Our own result on the CDB means the functional unit is done with us.
        if (cdb_en && cdb_label == my_tag) state_nx = ST_FREE;
      end
      default: state_nx = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FREE;
      op    <= '0;
      vj    <= '0;
      vk    <= '0;
      qj    <= NO_TAG;
      qk    <= NO_TAG;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      vj    <= vj_nx;
      vk    <= vk_nx;
      qj    <= qj_nx;
      qk    <= qk_nx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reservation_station.sv
// Reservation station: lowest-index allocation of FREE entries, issue-time CDB
// bypass, and lowest-index dispatch of READY entries to one functional unit.
`default_nettype none

module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int         N_ENTRIES  = 3,
  parameter logic [3:0] BASE_LABEL = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issueEN,
  input  logic [3:0]  issueOp,
  input  logic [31:0] issueVj,
  input  logic [31:0] issueVk,
  input  logic [3:0]  issueQj,
  input  logic [3:0]  issueQk,
  output logic        full,
  input  logic        cdbEN,
  input  logic [31:0] cdbData,
  input  logic [3:0]  cdbLabel,
  input  logic        fuReady,
  output logic        dispatchEN,
  output logic [3:0]  dispatchOp,
  output logic [31:0] dispatchA,
  output logic [31:0] dispatchB,
  output logic [3:0]  dispatchLabel
);

  entry_state_t          ent_state [N_ENTRIES];
  logic [OP_W-1:0]       ent_op    [N_ENTRIES];
  logic [DATA_W-1:0]     ent_vj    [N_ENTRIES];
  logic [DATA_W-1:0]     ent_vk    [N_ENTRIES];
  logic [N_ENTRIES-1:0]  alloc_sel, disp_sel;
  logic                  any_free, any_ready;
  logic                  byp_j, byp_k;
  logic [DATA_W-1:0]     eff_vj, eff_vk;
  logic [TAG_W-1:0]      eff_qj, eff_qk;

  // A producer broadcasting in the issue cycle would otherwise be missed forever.
  assign byp_j  = cdbEN && (issueQj != NO_TAG) && (issueQj == cdbLabel);
  assign byp_k  = cdbEN && (issueQk != NO_TAG) && (issueQk == cdbLabel);
  assign eff_vj = byp_j ? cdbData : issueVj;
  assign eff_vk = byp_k ? cdbData : issueVk;
  assign eff_qj = byp_j ? NO_TAG : issueQj;
  assign eff_qk = byp_k ? NO_TAG : issueQk;

  always_comb begin
    alloc_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!any_free && ent_state[i] == ST_FREE) begin
        any_free     = 1'b1;
        alloc_sel[i] = issueEN;
      end
    end
  end

  assign full = !any_free;

  always_comb begin
    disp_sel      = '0;
    any_ready     = 1'b0;
    dispatchOp    = '0;
    dispatchA     = '0;
    dispatchB     = '0;
    dispatchLabel = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!any_ready && ent_state[i] == ST_READY) begin
        any_ready = 1'b1;
        if (fuReady) begin
          disp_sel[i]   = 1'b1;
          dispatchOp    = ent_op[i];
          dispatchA     = ent_vj[i];
          dispatchB     = ent_vk[i];
          dispatchLabel = BASE_LABEL + 4'(i);
        end
      end
    end
  end

  assign dispatchEN = fuReady && any_ready;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
    rs_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .my_tag    (BASE_LABEL + 4'(g)),
      .alloc     (alloc_sel[g]),
      .dispatch  (disp_sel[g]),
      .issue_op  (issueOp),
      .issue_vj  (eff_vj),
      .issue_vk  (eff_vk),
      .issue_qj  (eff_qj),
      .issue_qk  (eff_qk),
      .cdb_en    (cdbEN),
      .cdb_data  (cdbData),
      .cdb_label (cdbLabel),
      .state     (ent_state[g]),
      .op        (ent_op[g]),
      .vj        (ent_vj[g]),
      .vk        (ent_vk[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (3 entries, tags 1..3).
`default_nettype none

module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueEN;
  logic [3:0]  issueOp;
  logic [31:0] issueVj, issueVk;
  logic [3:0]  issueQj, issueQk;
  logic        full;
  logic        cdbEN;
  logic [31:0] cdbData;
  logic [3:0]  cdbLabel;
  logic        fuReady;
  logic        dispatchEN;
  logic [3:0]  dispatchOp;
  logic [31:0] dispatchA, dispatchB;
  logic [3:0]  dispatchLabel;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  reservation_station #(.N_ENTRIES(3), .BASE_LABEL(4'd1)) dut (
    .clk           (clk),
    .rst           (rst),
    .issueEN       (issueEN),
    .issueOp       (issueOp),
    .issueVj       (issueVj),
    .issueVk       (issueVk),
    .issueQj       (issueQj),
    .issueQk       (issueQk),
    .full          (full),
    .cdbEN         (cdbEN),
    .cdbData       (cdbData),
    .cdbLabel      (cdbLabel),
    .fuReady       (fuReady),
    .dispatchEN    (dispatchEN),
    .dispatchOp    (dispatchOp),
    .dispatchA     (dispatchA),
    .dispatchB     (dispatchB),
    .dispatchLabel (dispatchLabel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issueEN = 1'b0; issueOp = '0; issueVj = '0; issueVk = '0; issueQj = '0; issueQk = '0;
    cdbEN = 1'b0; cdbData = '0; cdbLabel = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic [3:0] qk);
    issueEN = 1'b1; issueOp = op; issueVj = vj; issueVk = vk; issueQj = qj; issueQk = qk;
  endtask

  task automatic cdb(input logic [3:0] label, input logic [31:0] data);
    cdbEN = 1'b1; cdbLabel = label; cdbData = data;
  endtask

  task automatic chk_disp(input string tag, input logic en, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] label);
    chk({tag, ".en"}, 32'(dispatchEN), 32'(en));
    chk({tag, ".op"}, 32'(dispatchOp), 32'(op));
    chk({tag, ".a"}, dispatchA, a);
    chk({tag, ".b"}, dispatchB, b);
    chk({tag, ".label"}, 32'(dispatchLabel), 32'(label));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    fuReady = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset.full", 32'(full), 32'd0);
    chk_disp("reset.disp", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);

    // Simple issue with valid operands dispatches the following cycle
    issue(4'd2, 32'd5, 32'd7, 4'd0, 4'd0);
    #1;
    chk("basic.issue_cycle_en", 32'(dispatchEN), 32'd0);
    tick(); idle(); #1;
    chk_disp("basic.disp", 1'b1, 4'd2, 32'd5, 32'd7, 4'd1);
    tick(); #1;
    chk("basic.after_en", 32'(dispatchEN), 32'd0);
    cdb(4'd1, 32'h123);
    tick(); idle();

    // Operand waits on tag 4, captured from the CDB
    issue(4'd3, 32'hAA, 32'd3, 4'd4, 4'd0);
    tick(); idle(); #1;
    chk("wait.en0", 32'(dispatchEN), 32'd0);
    cdb(4'd4, 32'h10);
    #1;
    chk("wait.capture_cycle_en", 32'(dispatchEN), 32'd0);
    tick(); idle(); #1;
    chk_disp("wait.disp", 1'b1, 4'd3, 32'h10, 32'd3, 4'd1);
    tick();
    cdb(4'd1, 32'h0);
    tick(); idle();

    // Same-cycle bypass at issue
    issue(4'd5, 32'd0, 32'd6, 4'd4, 4'd0);
    cdb(4'd4, 32'd9);
    tick(); idle(); #1;
    chk_disp("bypass.disp", 1'b1, 4'd5, 32'd9, 32'd6, 4'd1);
    tick();
    cdb(4'd1, 32'h0);
    tick(); idle(); #1;
    chk("bypass.freed_full", 32'(full), 32'd0);

    // Fill, ignore 4th issue, free entry 1, reissue into entry 1
    fuReady = 1'b0;
    issue(4'd1, 32'h11, 32'h1, 4'd0, 4'd0); tick();
    issue(4'd2, 32'h22, 32'h2, 4'd0, 4'd0); tick(); #1;
    chk("fill.full_after2", 32'(full), 32'd0);
    issue(4'd3, 32'h33, 32'h3, 4'd0, 4'd0); tick(); #1;
    chk("fill.full_after3", 32'(full), 32'd1);
    issue(4'd7, 32'h77, 32'h7, 4'd0, 4'd0); tick(); idle(); #1;
    chk("fill.full_after4", 32'(full), 32'd1);
    chk("fill.hold_en", 32'(dispatchEN), 32'd0);
    fuReady = 1'b1; #1;
    chk_disp("fill.disp0", 1'b1, 4'd1, 32'h11, 32'h1, 4'd1);
    tick(); #1;
    chk_disp("fill.disp1", 1'b1, 4'd2, 32'h22, 32'h2, 4'd2);
    tick();
    fuReady = 1'b0;
    cdb(4'd2, 32'h5);
    #1;
    chk("fill.full_during_free", 32'(full), 32'd1);
    tick(); idle(); #1;
    chk("fill.full_after_free", 32'(full), 32'd0);
    issue(4'd9, 32'h99, 32'h0, 4'd0, 4'd0);
    tick(); idle(); #1;
    chk("fill.full_reissue", 32'(full), 32'd1);
    fuReady = 1'b1; #1;
    chk_disp("fill.disp_reissued", 1'b1, 4'd9, 32'h99, 32'h0, 4'd2);
    tick(); #1;
    chk_disp("fill.disp2", 1'b1, 4'd3, 32'h33, 32'h3, 4'd3);
    tick();

    rst = 1'b1; tick(); rst = 1'b0;

    // Two READY entries held by fuReady=0, then dispatched in index order
    fuReady = 1'b0;
    issue(4'd1, 32'd1, 32'd1, 4'd0, 4'd0); tick();
    issue(4'd2, 32'd2, 32'd2, 4'd4, 4'd0); tick();
    issue(4'd3, 32'd3, 32'd3, 4'd0, 4'd0); tick(); idle(); #1;
    chk_disp("prio.held", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    fuReady = 1'b1;
    cdb(4'd5, 32'hDEAD);
    #1;
    chk_disp("prio.first", 1'b1, 4'd1, 32'd1, 32'd1, 4'd1);
    tick(); idle(); #1;
    chk_disp("prio.second", 1'b1, 4'd3, 32'd3, 32'd3, 4'd3);
    tick(); #1;
    chk("prio.none_left", 32'(dispatchEN), 32'd0);
    chk("prio.full", 32'(full), 32'd1);

    // Reset with WAITING and EXECUTING entries, plus concurrent issue and CDB
    rst = 1'b1;
    issue(4'd6, 32'd6, 32'd6, 4'd0, 4'd0);
    cdb(4'd4, 32'h44);
    tick(); rst = 1'b0; idle(); #1;
    chk("rst.full", 32'(full), 32'd0);
    chk_disp("rst.disp", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    cdb(4'd3, 32'h5);
    tick(); idle(); #1;
    chk("rst.late_cdb_full", 32'(full), 32'd0);
    chk("rst.late_cdb_en", 32'(dispatchEN), 32'd0);
    issue(4'd4, 32'hC, 32'hD, 4'd0, 4'd0);
    tick(); idle(); #1;
    chk_disp("rst.reissue", 1'b1, 4'd4, 32'hC, 32'hD, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
